alu_operand_sequencer: RTL

Front-end controller that drives the 8-bit ALU's operand and opcode inputs, then collects its result. It reads the 16 board switches and the BTNC centre button and steps the user through operand entry, opcode entry, execution and result display. It presents registered `number1`/`number2`/`opcode` to the ALU, captures `resultant` after the ALU pipeline latency, and drives the value and digit-enable words for the 7-segment display driver.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/alu_operand_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU front-end sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        S_OPERANDS,
        S_OPCODE,
        S_EXEC,
        S_RESULT
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_MAX = 4'd4;

    localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFF;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Any sample matching the accepted level restarts the stability window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Switch/button front end for the 8-bit ALU: operand entry, opcode entry, execute, display.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned ALU_LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_sw,
    input  logic        i_btnc,
    output logic [7:0]  o_number1,
    output logic [7:0]  o_number2,
    output logic [3:0]  o_opcode,
    input  logic [15:0] i_resultant,
    output logic [15:0] o_result,
    output logic        o_result_valid,
    output logic        o_div_zero,
    output logic        o_op_err,
    output logic [31:0] o_disp_value,
    output logic [7:0]  o_disp_en
);

    localparam int unsigned EW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    state_t        r_state;
    logic [7:0]    r_number1;
    logic [7:0]    r_number2;
    logic [3:0]    r_opcode;
    logic [15:0]   r_result;
    logic          r_result_valid;
    logic          r_div_zero;
    logic [31:0]   r_disp_value;
    logic [7:0]    r_disp_en;
    logic [EW-1:0] r_exec_cnt;

    logic       w_press;
    logic       w_level;
    logic       w_go;
    logic [3:0] w_op_sel;
    logic       w_op_illegal;
    logic       w_div_by_zero;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btnc),
        .o_level (w_level),
        .o_press (w_press)
    );

    // Accept a press only while the debounced level is still held.
    assign w_go          = w_press & w_level;
    assign w_op_sel      = i_sw[3:0];
    assign w_op_illegal  = w_op_sel > OP_MAX;
    assign w_div_by_zero = is_div_op(w_op_sel) && (r_number2 == 8'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_OPERANDS;
            r_number1      <= '0;
            r_number2      <= '0;
            r_opcode       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_div_zero     <= 1'b0;
            r_disp_value   <= '0;
            r_disp_en      <= 8'hF0;
            r_exec_cnt     <= '0;
        end else begin
            unique case (r_state)
                S_OPERANDS: begin
                    if (w_go) begin
                        r_number1  <= i_sw[15:8];
                        r_number2  <= i_sw[7:0];
                        r_div_zero <= 1'b0;
                        r_state    <= S_OPCODE;
                    end
                end
                S_OPCODE: begin
                    if (w_go && !w_op_illegal) begin
                        if (w_div_by_zero) begin
                            r_result       <= DIV_ZERO_RESULT;
                            r_div_zero     <= 1'b1;
                            r_result_valid <= 1'b1;
                            r_state        <= S_RESULT;
                        end else begin
                            r_opcode   <= w_op_sel;
                            r_exec_cnt <= EW'(ALU_LATENCY);
                            r_state    <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    // Presses arriving here are intentionally dropped.
                    if (r_exec_cnt == '0) begin
                        r_result       <= i_resultant;
                        r_result_valid <= 1'b1;
                        r_state        <= S_RESULT;
                    end else begin
                        r_exec_cnt <= r_exec_cnt - EW'(1);
                    end
                end
                S_RESULT: begin
                    if (w_go) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_OPERANDS;
                    end
                end
            endcase

            unique case (r_state)
                S_OPERANDS: begin
                    r_disp_value <= {i_sw, 16'h0000};
                    r_disp_en    <= 8'hF0;
                end
                S_OPCODE: begin
                    r_disp_value <= {r_number1, r_number2, 12'h000, w_op_sel};
                    r_disp_en    <= 8'hF1;
                end
                S_EXEC: begin
                    r_disp_value <= {r_number1, r_number2, 16'h0000};
                    r_disp_en    <= 8'hF0;
                end
                S_RESULT: begin
                    r_disp_value <= {r_number1, r_number2, r_result};
                    r_disp_en    <= 8'hFF;
                end
            endcase
        end
    end

    assign o_number1      = r_number1;
    assign o_number2      = r_number2;
    assign o_opcode       = r_opcode;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_div_zero     = r_div_zero;
    assign o_op_err       = (r_state == S_OPCODE) && w_op_illegal;
    assign o_disp_value   = r_disp_value;
    assign o_disp_en      = r_disp_en;

endmodule
